// File: rtl/pc_stack.sv
// Program counter with increment, absolute/relative jumps, and call/return through a circular return-address stack.
// Optional macro PC_RAS_WRAP_EN: a call on a full stack overwrites the oldest entry instead of dropping the push.
module pc_stack #(
  parameter int unsigned     PC_W       = 10,
  parameter int unsigned     OFF_W      = 8,
  parameter int unsigned     RAS_DEPTH  = 4,
  parameter logic [PC_W-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             absjump_en,
  input  logic [PC_W-1:0]  target,
  input  logic             reljump_en,
  input  logic [OFF_W-1:0] offset,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic             err_q, err_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];

  logic             push_en;
  logic [PTR_W-1:0] push_addr;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  off_ext;
  logic             empty_w, full_w;

  assign pc_inc  = pc_q + PC_W'(1);
  assign off_ext = PC_W'($signed(offset));
  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == CNT_W'(RAS_DEPTH));

  always_comb begin
    pc_d      = pc_inc;
    cnt_d     = cnt_q;
    top_d     = top_q;
    err_d     = 1'b0;
    push_en   = 1'b0;
    push_addr = top_q + PTR_W'(1);
    if (stall) begin
      pc_d = pc_q;
    end else if (ret_en) begin
      if (!empty_w) begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (call_en) begin
      pc_d = target;
      if (!full_w) begin
        push_en = 1'b1;
        top_d   = push_addr;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
`ifdef PC_RAS_WRAP_EN
        // Pointer advances onto the oldest slot; count is already saturated.
        push_en = 1'b1;
        top_d   = push_addr;
`else
        err_d   = 1'b1;
`endif
      end
    end else if (absjump_en) begin
      pc_d = target;
    end else if (reljump_en) begin
      pc_d = pc_q + off_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      cnt_q <= '0;
      top_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      err_q <= err_d;
    end
  end

  // Stack storage carries no reset; slots are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      ras_q[push_addr] <= pc_inc;
    end
  end

  assign prog_ctr  = pc_q;
  assign ras_empty = empty_w;
  assign ras_full  = full_w;
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: a vector table walked in order, plus a nested-call overflow sequence.
module tb_pc_stack;

  logic       clk = 1'b0;
  logic       reset, stall, absjump_en, reljump_en, call_en, ret_en;
  logic [9:0] target;
  logic [7:0] offset;
  logic [9:0] prog_ctr;
  logic       ras_empty, ras_full, ras_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pc_stack #(.PC_W(10), .OFF_W(8), .RAS_DEPTH(4), .RESET_ADDR(10'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .absjump_en (absjump_en),
    .target     (target),
    .reljump_en (reljump_en),
    .offset     (offset),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .prog_ctr   (prog_ctr),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_err    (ras_err)
  );

  always #5 clk = ~clk;

  // control bits: {reset, stall, ret, call, abs, rel}
  localparam logic [5:0] NO = 6'b000000;
  localparam logic [5:0] RS = 6'b100000;
  localparam logic [5:0] ST = 6'b010000;
  localparam logic [5:0] RT = 6'b001000;
  localparam logic [5:0] CL = 6'b000100;
  localparam logic [5:0] AB = 6'b000010;
  localparam logic [5:0] RL = 6'b000001;

  typedef struct {
    logic [5:0] ctl;
    logic [9:0] tgt;
    logic [7:0] off;
    logic [9:0] pc;
    logic       empty;
    logic       full;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [5:0] ctl, logic [9:0] tgt, logic [7:0] off,
                              logic [9:0] pc, logic empty, logic full, logic err);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.off = off;
    v.pc = pc; v.empty = empty; v.full = full; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Drive one cycle's controls, let the edge happen, then compare the registered state.
  task automatic apply(input string tag, input vec_t v);
    {reset, stall, ret_en, call_en, absjump_en, reljump_en} = v.ctl;
    target = v.tgt;
    offset = v.off;
    @(posedge clk);
    #1;
    chk({tag, " pc"},    32'(prog_ctr),  32'(v.pc));
    chk({tag, " empty"}, 32'(ras_empty), 32'(v.empty));
    chk({tag, " full"},  32'(ras_full),  32'(v.full));
    chk({tag, " err"},   32'(ras_err),   32'(v.err));
  endtask

  initial begin
    {reset, stall, ret_en, call_en, absjump_en, reljump_en} = RS;
    target = '0;
    offset = '0;

    vecs.push_back(mk(RS,           10'd0,   8'h00, 10'd0,   1, 0, 0));
    vecs.push_back(mk(RS,           10'd0,   8'h00, 10'd0,   1, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd1,   1, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd2,   1, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd3,   1, 0, 0));
    vecs.push_back(mk(AB,           10'd1023,8'h00, 10'd1023,1, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd0,   1, 0, 0));
    vecs.push_back(mk(AB,           10'd8,   8'h00, 10'd8,   1, 0, 0));
    vecs.push_back(mk(RL,           10'd0,   8'hFD, 10'd5,   1, 0, 0));
    vecs.push_back(mk(RL,           10'd0,   8'h00, 10'd5,   1, 0, 0));
    vecs.push_back(mk(AB | RL,      10'd100, 8'hFD, 10'd100, 1, 0, 0));
    vecs.push_back(mk(AB,           10'd20,  8'h00, 10'd20,  1, 0, 0));
    vecs.push_back(mk(CL,           10'd100, 8'h00, 10'd100, 0, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd101, 0, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd102, 0, 0, 0));
    vecs.push_back(mk(RT,           10'd0,   8'h00, 10'd21,  1, 0, 0));
    vecs.push_back(mk(AB,           10'd7,   8'h00, 10'd7,   1, 0, 0));
    vecs.push_back(mk(RT,           10'd0,   8'h00, 10'd8,   1, 0, 1));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd9,   1, 0, 0));
    vecs.push_back(mk(AB,           10'd40,  8'h00, 10'd40,  1, 0, 0));
    vecs.push_back(mk(ST | CL,      10'd300, 8'h00, 10'd40,  1, 0, 0));
    vecs.push_back(mk(ST | CL,      10'd300, 8'h00, 10'd40,  1, 0, 0));
    vecs.push_back(mk(ST | CL,      10'd300, 8'h00, 10'd40,  1, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd41,  1, 0, 0));
    vecs.push_back(mk(RL,           10'd0,   8'h80, 10'd937, 1, 0, 0));
    vecs.push_back(mk(CL,           10'd500, 8'h00, 10'd500, 0, 0, 0));
    vecs.push_back(mk(CL,           10'd600, 8'h00, 10'd600, 0, 0, 0));
    vecs.push_back(mk(RS | CL,      10'd700, 8'h00, 10'd0,   1, 0, 0));
    vecs.push_back(mk(RT,           10'd0,   8'h00, 10'd1,   1, 0, 1));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd2,   1, 0, 0));
    vecs.push_back(mk(CL,           10'd50,  8'h00, 10'd50,  0, 0, 0));
    vecs.push_back(mk(RT | CL | AB, 10'd700, 8'h00, 10'd3,   1, 0, 0));
    vecs.push_back(mk(NO,           10'd0,   8'h00, 10'd4,   1, 0, 0));

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Five nested calls into a four-deep stack, then five returns.
    apply("ovf rst",   mk(RS, 10'd0,   8'h00, 10'd0,   1, 0, 0));
    apply("ovf jmp",   mk(AB, 10'd10,  8'h00, 10'd10,  1, 0, 0));
    apply("ovf call1", mk(CL, 10'd200, 8'h00, 10'd200, 0, 0, 0));
    apply("ovf call2", mk(CL, 10'd300, 8'h00, 10'd300, 0, 0, 0));
    apply("ovf call3", mk(CL, 10'd400, 8'h00, 10'd400, 0, 0, 0));
    apply("ovf call4", mk(CL, 10'd500, 8'h00, 10'd500, 0, 1, 0));
`ifdef PC_RAS_WRAP_EN
    apply("ovf call5", mk(CL, 10'd600, 8'h00, 10'd600, 0, 1, 0));
    apply("ovf ret1",  mk(RT, 10'd0,   8'h00, 10'd501, 0, 0, 0));
    apply("ovf ret2",  mk(RT, 10'd0,   8'h00, 10'd401, 0, 0, 0));
    apply("ovf ret3",  mk(RT, 10'd0,   8'h00, 10'd301, 0, 0, 0));
    apply("ovf ret4",  mk(RT, 10'd0,   8'h00, 10'd201, 1, 0, 0));
    apply("ovf ret5",  mk(RT, 10'd0,   8'h00, 10'd202, 1, 0, 1));
`else
    apply("ovf call5", mk(CL, 10'd600, 8'h00, 10'd600, 0, 1, 1));
    apply("ovf ret1",  mk(RT, 10'd0,   8'h00, 10'd401, 0, 0, 0));
    apply("ovf ret2",  mk(RT, 10'd0,   8'h00, 10'd301, 0, 0, 0));
    apply("ovf ret3",  mk(RT, 10'd0,   8'h00, 10'd201, 0, 0, 0));
    apply("ovf ret4",  mk(RT, 10'd0,   8'h00, 10'd11,  1, 0, 0));
    apply("ovf ret5",  mk(RT, 10'd0,   8'h00, 10'd12,  1, 0, 1));
`endif
    apply("ovf idle",  mk(NO, 10'd0,   8'h00, (prog_ctr + 10'd1), 1, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
